// File: rtl/sdram2fifo.sv
// SDRAM read side: issues burst read requests, captures W_RDDAT words into a
// show-ahead FIFO and streams pixels out; addressing restarts on each frame start.
module sdram2fifo #(
  parameter int          DEPTH       = 1024,
  parameter int          BURST_LEN   = 256,
  parameter logic [21:0] BASE_ADDR   = 22'd0,
  parameter int          FRAME_WORDS = 307200,
  parameter logic [4:0]  W_RDDAT     = 5'd6
) (
  input  logic                       clk_133M_i,
  input  logic                       rst_133i,
  input  logic [4:0]                 work_st,
  input  logic [15:0]                rd_sdram_data,
  output logic                       rd_req_o,
  output logic [21:0]                rd_addr_o,
  input  logic                       rd_ack_i,
  input  logic                       frame_start_i,
  output logic [15:0]                pix_data_o,
  output logic                       pix_valid_o,
  input  logic                       pix_ready_i,
  output logic [$clog2(DEPTH):0]     fifo_used_o,
  output logic                       underflow_o,
  output logic                       overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int UW = AW + 1;
  localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT, R_FLUSH} state_e;

  state_e          state_q, state_d;
  logic [15:0]     mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [UW-1:0]   used_q, used_d;
  logic [21:0]     addr_q, addr_d, addr_inc;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            flush_pend_q, flush_pend_d;
  logic            unf_q, unf_d, ovf_q, ovf_d;
  logic            rddat, full, valid, pop, push, flush;

  assign rddat    = (work_st == W_RDDAT);
  assign full     = (used_q == UW'(DEPTH));
  assign valid    = (used_q != '0);
  assign pop      = valid & pix_ready_i;
  // A full FIFO still accepts the word when the head leaves in the same cycle.
  assign push     = rddat & (~full | pop);
  assign flush    = (state_q == R_FLUSH);
  assign addr_inc = addr_q + 22'(BURST_LEN);

  assign rd_req_o    = (state_q == R_REQ);
  assign rd_addr_o   = addr_q;
  assign pix_valid_o = valid;
  assign pix_data_o  = valid ? mem_q[rptr_q] : 16'd0;
  assign fifo_used_o = used_q;
  assign underflow_o = unf_q;
  assign overflow_o  = ovf_q;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    used_d = used_q;
    unf_d  = unf_q | (pix_ready_i & ~valid);
    ovf_d  = ovf_q | (rddat & full & ~pop);
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      used_d = '0;
      unf_d  = 1'b0;
      ovf_d  = 1'b0;
    end else begin
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      if (push && !pop)      used_d = used_q + UW'(1);
      else if (pop && !push) used_d = used_q - UW'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q | frame_start_i;
    case (state_q)
      R_IDLE: begin
        if (flush_pend_q)                            state_d = R_FLUSH;
        else if (used_q <= UW'(DEPTH - BURST_LEN))   state_d = R_REQ;
      end
      R_REQ: begin
        if (rd_ack_i) begin
          cnt_d   = '0;
          state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        // Dropped words still count, so the burst always ends on the controller's schedule.
        if (rddat) begin
          if (cnt_q == CW'(BURST_LEN - 1)) begin
            cnt_d   = '0;
            state_d = R_IDLE;
            addr_d  = (addr_inc == BASE_ADDR + 22'(FRAME_WORDS)) ? BASE_ADDR : addr_inc;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      R_FLUSH: begin
        addr_d       = BASE_ADDR;
        flush_pend_d = frame_start_i;
        state_d      = R_IDLE;
      end
      default: state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_133M_i) begin
    if (!rst_133i) begin
      state_q      <= R_IDLE;
      addr_q       <= BASE_ADDR;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      used_q       <= '0;
      unf_q        <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      used_q       <= used_d;
      unf_q        <= unf_d;
      ovf_q        <= ovf_d;
    end
  end

  // Storage is data only; it needs no reset since occupancy gates every read.
  always_ff @(posedge clk_133M_i) begin
    if (push) mem_q[wptr_q] <= rd_sdram_data;
  end

endmodule

// File: tb/tb_sdram2fifo.sv
// Directed bench for sdram2fifo: default instance for fill/drain/flush/flags,
// a small-frame instance with a non-zero base for the address wrap.
module tb_sdram2fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  work_st;
  logic [15:0] rd_data;
  logic        ack, fs, ready;
  logic        req;
  logic [21:0] addr;
  logic [15:0] pix;
  logic        valid, unf, ovf;
  logic [10:0] used;

  logic [4:0]  work_st2;
  logic [15:0] rd_data2;
  logic        ack2, req2, valid2, unf2, ovf2;
  logic [21:0] addr2;
  logic [15:0] pix2;
  logic [4:0]  used2;

  int nvec = 0;
  int nerr = 0;

  always #4 clk = ~clk;

  sdram2fifo dut (
    .clk_133M_i(clk), .rst_133i(rst), .work_st(work_st), .rd_sdram_data(rd_data),
    .rd_req_o(req), .rd_addr_o(addr), .rd_ack_i(ack), .frame_start_i(fs),
    .pix_data_o(pix), .pix_valid_o(valid), .pix_ready_i(ready),
    .fifo_used_o(used), .underflow_o(unf), .overflow_o(ovf)
  );

  sdram2fifo #(.DEPTH(16), .BURST_LEN(8), .BASE_ADDR(22'd100), .FRAME_WORDS(24)) dut2 (
    .clk_133M_i(clk), .rst_133i(rst), .work_st(work_st2), .rd_sdram_data(rd_data2),
    .rd_req_o(req2), .rd_addr_o(addr2), .rd_ack_i(ack2), .frame_start_i(1'b0),
    .pix_data_o(pix2), .pix_valid_o(valid2), .pix_ready_i(1'b1),
    .fifo_used_o(used2), .underflow_o(unf2), .overflow_o(ovf2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
  endtask

  // Wait for a request, check its address, ack it and deliver one 256-word burst.
  task automatic do_burst(input logic [21:0] exp_addr, input int first, input int fs_at);
    int n = 0;
    while (!req && n < 100) begin
      tick();
      n++;
    end
    nvec++;
    if (req !== 1'b1 || addr !== exp_addr) begin
      nerr++;
      $display("FAIL burst_req: req=%0b addr=%0d, required req=1 addr=%0d", req, addr, exp_addr);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    nvec++;
    if (req !== 1'b0) begin
      nerr++;
      $display("FAIL req_drop: req=%0b, required 0", req);
    end
    for (int j = 0; j < 256; j++) begin
      work_st = 5'd6;
      rd_data = 16'(first + j);
      fs      = (j == fs_at);
      tick();
    end
    work_st = 5'd0;
    fs      = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    nvec++;
    if (used !== 11'd0 || req !== 1'b0 || addr !== 22'd0 || valid !== 1'b0 ||
        pix !== 16'd0 || unf !== 1'b0 || ovf !== 1'b0) begin
      nerr++;
      $display("FAIL reset_state: used=%0d req=%0b addr=%0d valid=%0b pix=%0d unf=%0b ovf=%0b, required all 0",
               used, req, addr, valid, pix, unf, ovf);
    end
    tick();
    nvec++;
    if (req !== 1'b1 || addr !== 22'd0) begin
      nerr++;
      $display("FAIL first_req: req=%0b addr=%0d, required req=1 addr=0", req, addr);
    end
    do_burst(22'd0, 0, -1);
    nvec++;
    if (used !== 11'd256 || valid !== 1'b1 || pix !== 16'd0) begin
      nerr++;
      $display("FAIL first_burst: used=%0d valid=%0b pix=%0d, required 256 1 0", used, valid, pix);
    end
  endtask

  task automatic test_fill();
    int reqs = 0;
    do_burst(22'd256, 256, -1);
    do_burst(22'd512, 512, -1);
    do_burst(22'd768, 768, -1);
    nvec++;
    if (used !== 11'd1024) begin
      nerr++;
      $display("FAIL fill_used: used=%0d, required 1024", used);
    end
    for (int i = 0; i < 20; i++) begin
      if (req) reqs++;
      tick();
    end
    nvec++;
    if (reqs != 0 || ovf !== 1'b0 || addr !== 22'd1024) begin
      nerr++;
      $display("FAIL fill_hold: req_cycles=%0d ovf=%0b addr=%0d, required 0 0 1024", reqs, ovf, addr);
    end
  endtask

  task automatic test_drain();
    int bad = 0;
    for (int i = 0; i < 256; i++) begin
      ready = 1'b1;
      if (i == 100) begin
        nvec++;
        if (used !== 11'd924) begin
          nerr++;
          $display("FAIL drain_used: used=%0d, required 924", used);
        end
      end
      if (pix !== 16'(i) || valid !== 1'b1) bad++;
      tick();
    end
    ready = 1'b0;
    nvec++;
    if (bad != 0) begin
      nerr++;
      $display("FAIL drain_order: bad_words=%0d, required 0", bad);
    end
    nvec++;
    if (used !== 11'd768 || pix !== 16'd256) begin
      nerr++;
      $display("FAIL drain_end: used=%0d pix=%0d, required 768 256", used, pix);
    end
    do_burst(22'd1024, 1024, -1);
    nvec++;
    if (used !== 11'd1024) begin
      nerr++;
      $display("FAIL refill: used=%0d, required 1024", used);
    end
  endtask

  task automatic test_flush();
    int n = 0;
    do_reset();
    do_burst(22'd0, 0, -1);
    do_burst(22'd256, 256, -1);
    do_burst(22'd512, 512, 100);
    nvec++;
    if (used !== 11'd768 || req !== 1'b0) begin
      nerr++;
      $display("FAIL flush_burst_done: used=%0d req=%0b, required 768 0", used, req);
    end
    tick();
    nvec++;
    if (used !== 11'd768 || req !== 1'b0) begin
      nerr++;
      $display("FAIL flush_enter: used=%0d req=%0b, required 768 0", used, req);
    end
    tick();
    nvec++;
    if (used !== 11'd0 || addr !== 22'd0 || req !== 1'b0 || valid !== 1'b0) begin
      nerr++;
      $display("FAIL flush_done: used=%0d addr=%0d req=%0b valid=%0b, required 0 0 0 0",
               used, addr, req, valid);
    end
    while (!req && n < 100) begin
      tick();
      n++;
    end
    nvec++;
    if (req !== 1'b1 || addr !== 22'd0) begin
      nerr++;
      $display("FAIL flush_next_req: req=%0b addr=%0d, required 1 0", req, addr);
    end
  endtask

  task automatic test_flags();
    nvec++;
    if (unf !== 1'b0) begin
      nerr++;
      $display("FAIL unf_pre: unf=%0b, required 0", unf);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    repeat (3) tick();
    nvec++;
    if (unf !== 1'b1 || used !== 11'd0) begin
      nerr++;
      $display("FAIL unf_set: unf=%0b used=%0d, required 1 0", unf, used);
    end
    do_burst(22'd0, 0, -1);
    do_burst(22'd256, 256, -1);
    do_burst(22'd512, 512, -1);
    do_burst(22'd768, 768, -1);
    nvec++;
    if (used !== 11'd1024 || ovf !== 1'b0 || unf !== 1'b1) begin
      nerr++;
      $display("FAIL full_pre_ovf: used=%0d ovf=%0b unf=%0b, required 1024 0 1", used, ovf, unf);
    end
    work_st = 5'd6;
    rd_data = 16'hBEEF;
    tick();
    work_st = 5'd0;
    nvec++;
    if (ovf !== 1'b1 || used !== 11'd1024 || pix !== 16'd0) begin
      nerr++;
      $display("FAIL ovf_set: ovf=%0b used=%0d pix=%0d, required 1 1024 0", ovf, used, pix);
    end
    fs = 1'b1;
    tick();
    fs = 1'b0;
    repeat (2) tick();
    nvec++;
    if (ovf !== 1'b0 || unf !== 1'b0 || used !== 11'd0 || addr !== 22'd0) begin
      nerr++;
      $display("FAIL flags_clear: ovf=%0b unf=%0b used=%0d addr=%0d, required 0 0 0 0", ovf, unf, used, addr);
    end
  endtask

  task automatic test_wrap();
    logic [21:0] exp_a [4];
    int bad = 0;
    exp_a = '{22'd100, 22'd108, 22'd116, 22'd100};
    for (int k = 0; k < 4; k++) begin
      int n = 0;
      while (!req2 && n < 100) begin
        tick();
        n++;
      end
      nvec++;
      if (req2 !== 1'b1 || addr2 !== exp_a[k]) begin
        nerr++;
        $display("FAIL wrap_addr%0d: req=%0b addr=%0d, required 1 %0d", k, req2, addr2, exp_a[k]);
      end
      ack2 = 1'b1;
      tick();
      ack2 = 1'b0;
      for (int j = 0; j < 8; j++) begin
        work_st2 = 5'd6;
        rd_data2 = 16'(k * 8 + j);
        tick();
        if (valid2 !== 1'b1 || pix2 !== 16'(k * 8 + j)) bad++;
      end
      work_st2 = 5'd0;
    end
    nvec++;
    if (bad != 0) begin
      nerr++;
      $display("FAIL wrap_stream: bad_words=%0d, required 0", bad);
    end
  endtask

  initial begin
    rst = 1'b0; work_st = 5'd0; rd_data = 16'd0; ack = 1'b0; fs = 1'b0; ready = 1'b0;
    work_st2 = 5'd0; rd_data2 = 16'd0; ack2 = 1'b0;
    test_reset();
    test_fill();
    test_drain();
    test_flush();
    test_flags();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
